// File: rtl/led_breathe.sv
// LED "breathing" driver: free-running PWM counter whose duty ramps up, holds,
// ramps down and holds again, advancing one step per requested tick at period boundaries.
module led_breathe #(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned STEP       = 1,
  parameter int unsigned HOLD_TICKS = 16
) (
  input  logic                CLK,
  input  logic                RESETN,
  input  logic                EN,
  input  logic                TICK,
  output logic                LED,
  output logic [PWM_BITS-1:0] LEVEL,
  output logic                DIR,
  output logic                WRAP
);

  localparam logic [1:0] S_RAMP_UP   = 2'd0;
  localparam logic [1:0] S_HOLD_HIGH = 2'd1;
  localparam logic [1:0] S_RAMP_DOWN = 2'd2;
  localparam logic [1:0] S_HOLD_LOW  = 2'd3;

  localparam logic [PWM_BITS-1:0] LVL_MAX = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS:0]   STEP_X  = (PWM_BITS+1)'(STEP);
  localparam logic [8:0]          HOLD_X  = 9'(HOLD_TICKS);

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [1:0]          state_q, state_d;
  logic [7:0]          hold_q, hold_d;
  logic                pending_q, pending_d;
  logic                led_q, led_d;

  logic                wrap;
  logic                apply;
  logic [PWM_BITS:0]   sum_up;
  logic [8:0]          hold_inc;

  assign wrap     = EN && (cnt_q == LVL_MAX);
  // A tick arriving in the wrap cycle itself is honoured immediately.
  assign apply    = wrap && (pending_q || TICK);
  assign sum_up   = {1'b0, level_q} + STEP_X;
  assign hold_inc = {1'b0, hold_q} + 9'd1;

  always_comb begin
    cnt_d     = EN ? cnt_q + 1'b1 : '0;
    pending_d = EN && !wrap && (pending_q || TICK);
    led_d     = EN && (cnt_q < level_q);
    level_d   = level_q;
    state_d   = state_q;
    hold_d    = hold_q;
    if (apply) begin
      case (state_q)
        S_RAMP_UP: begin
          if (sum_up >= {1'b0, LVL_MAX}) begin
            level_d = LVL_MAX;
            hold_d  = '0;
            state_d = S_HOLD_HIGH;
          end else begin
            level_d = sum_up[PWM_BITS-1:0];
          end
        end
        S_HOLD_HIGH: begin
          if (hold_inc >= HOLD_X) begin
            hold_d  = '0;
            state_d = S_RAMP_DOWN;
          end else begin
            hold_d = hold_inc[7:0];
          end
        end
        S_RAMP_DOWN: begin
          // Compare in the widened domain so a STEP above LEVEL never underflows.
          if ({1'b0, level_q} <= STEP_X) begin
            level_d = '0;
            hold_d  = '0;
            state_d = S_HOLD_LOW;
          end else begin
            level_d = level_q - STEP_X[PWM_BITS-1:0];
          end
        end
        default: begin
          if (hold_inc >= HOLD_X) begin
            hold_d  = '0;
            state_d = S_RAMP_UP;
          end else begin
            hold_d = hold_inc[7:0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cnt_q     <= '0;
      level_q   <= '0;
      state_q   <= S_RAMP_UP;
      hold_q    <= '0;
      pending_q <= 1'b0;
      led_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      led_q     <= led_d;
    end
  end

  assign LED   = led_q;
  assign LEVEL = level_q;
  assign DIR   = (state_q == S_RAMP_UP) || (state_q == S_HOLD_HIGH);
  assign WRAP  = wrap;

endmodule

// File: tb/tb_led_breathe.sv
// Bench for led_breathe: three parameterisations share one stimulus stream and are
// compared against a period-level behavioural model plus fixed expected sequences.
module tb_led_breathe;

  localparam int NI   = 3;
  localparam int MAXV = 255;
  localparam int STEPS [NI] = '{1, 100, 75};
  localparam int HOLDS [NI] = '{16, 16, 2};

  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  logic EN = 1'b0;
  logic TICK = 1'b0;
  logic [NI-1:0] led_w, dir_w, wrap_w;
  logic [7:0]    level_w [NI];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cnt;
    bit pend;
    int level;
    int phase; // 0 up, 1 hold high, 2 down, 3 hold low
    int hold;
    bit led;
  } mdl_t;

  mdl_t m [NI];

  always #5 CLK = ~CLK;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      led_breathe #(
        .PWM_BITS  (8),
        .STEP      (STEPS[gi]),
        .HOLD_TICKS(HOLDS[gi])
      ) u_dut (
        .CLK   (CLK),
        .RESETN(RESETN),
        .EN    (EN),
        .TICK  (TICK),
        .LED   (led_w[gi]),
        .LEVEL (level_w[gi]),
        .DIR   (dir_w[gi]),
        .WRAP  (wrap_w[gi])
      );
    end
  endgenerate

  // One clock of behaviour: duty compare, pending-tick collapse, step at period end.
  function automatic mdl_t adv(mdl_t s, bit en, bit tick, int step, int ht);
    mdl_t n;
    bit at_end;
    n = s;
    n.led = en && (s.cnt < s.level);
    if (!en) begin
      n.cnt  = 0;
      n.pend = 1'b0;
      return n;
    end
    at_end = (s.cnt == MAXV);
    n.cnt  = (s.cnt + 1) % (MAXV + 1);
    if (!at_end) begin
      n.pend = s.pend || tick;
      return n;
    end
    n.pend = 1'b0;
    if (!(s.pend || tick)) return n;
    case (s.phase)
      0: begin
        if (s.level + step >= MAXV) begin
          n.level = MAXV; n.phase = 1; n.hold = 0;
        end else n.level = s.level + step;
      end
      1: begin
        if (s.hold + 1 >= ht) begin n.hold = 0; n.phase = 2; end
        else n.hold = s.hold + 1;
      end
      2: begin
        if (s.level <= step) begin
          n.level = 0; n.phase = 3; n.hold = 0;
        end else n.level = s.level - step;
      end
      default: begin
        if (s.hold + 1 >= ht) begin n.hold = 0; n.phase = 0; end
        else n.hold = s.hold + 1;
      end
    endcase
    return n;
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < NI; i++) m[i] = '{default: 0};
  endtask

  task automatic rst();
    RESETN = 1'b0;
    EN = 1'b0;
    TICK = 1'b0;
    repeat (2) @(negedge CLK);
    RESETN = 1'b1;
    mdl_clear();
  endtask

  task automatic cyc(input bit en, input bit tick);
    EN = en;
    TICK = tick;
    @(posedge CLK);
    for (int i = 0; i < NI; i++) m[i] = adv(m[i], en, tick, STEPS[i], HOLDS[i]);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESETN = 1'b0; EN = 1'b1; TICK = 1'b1;
    repeat (2) @(negedge CLK);
    for (int i = 0; i < NI; i++) begin
      checks++; if (led_w[i] !== 1'b0) begin errors++; $display("FAIL reset_led[%0d]: got %b want 0", i, led_w[i]); end
      checks++; if (level_w[i] !== 8'd0) begin errors++; $display("FAIL reset_level[%0d]: got %0d want 0", i, level_w[i]); end
      checks++; if (dir_w[i] !== 1'b1) begin errors++; $display("FAIL reset_dir[%0d]: got %b want 1", i, dir_w[i]); end
      checks++; if (wrap_w[i] !== 1'b0) begin errors++; $display("FAIL reset_wrap[%0d]: got %b want 0", i, wrap_w[i]); end
    end
  endtask

  task automatic test_idle();
    int nw;
    rst();
    nw = 0;
    for (int k = 0; k < 1024; k++) begin
      cyc(1'b1, 1'b0);
      if (wrap_w[0] === 1'b1) nw++;
      for (int i = 0; i < NI; i++) begin
        checks++; if (led_w[i] !== 1'b0) begin errors++; $display("FAIL idle_led[%0d] k=%0d: got %b want 0", i, k, led_w[i]); end
        checks++; if (wrap_w[i] !== (m[i].cnt == MAXV)) begin errors++; $display("FAIL idle_wrap[%0d] k=%0d: got %b want %b", i, k, wrap_w[i], m[i].cnt == MAXV); end
      end
    end
    checks++; if (nw != 4) begin errors++; $display("FAIL idle_wrap_count: got %0d want 4", nw); end
    checks++; if (level_w[0] !== 8'd0) begin errors++; $display("FAIL idle_level: got %0d want 0", level_w[0]); end
  endtask

  task automatic test_duty64();
    int highs;
    rst();
    for (int p = 0; p < 64; p++)
      for (int c = 0; c < 256; c++) cyc(1'b1, c == 10);
    checks++; if (level_w[0] !== 8'd64) begin errors++; $display("FAIL duty_level: got %0d want 64", level_w[0]); end
    highs = 0;
    for (int k = 0; k < 256; k++) begin
      cyc(1'b1, 1'b0);
      if (led_w[0] === 1'b1) highs++;
      checks++; if (led_w[0] !== (k < 64)) begin errors++; $display("FAIL duty_led k=%0d: got %b want %b", k, led_w[0], k < 64); end
      for (int i = 1; i < NI; i++) begin
        checks++; if (led_w[i] !== m[i].led) begin errors++; $display("FAIL duty_led_model[%0d] k=%0d: got %b want %b", i, k, led_w[i], m[i].led); end
      end
    end
    checks++; if (highs != 64) begin errors++; $display("FAIL duty_high_count: got %0d want 64", highs); end
  endtask

  task automatic test_step100();
    int lv;
    bit dr;
    rst();
    for (int k = 1; k <= 38; k++) begin
      for (int c = 0; c < 256; c++) cyc(1'b1, c == 0);
      if (k <= 2)       begin lv = 100 * k; dr = 1'b1; end
      else if (k <= 18) begin lv = 255; dr = 1'b1; end
      else if (k == 19) begin lv = 255; dr = 1'b0; end
      else if (k == 20) begin lv = 155; dr = 1'b0; end
      else if (k == 21) begin lv = 55;  dr = 1'b0; end
      else if (k <= 37) begin lv = 0;   dr = 1'b0; end
      else              begin lv = 0;   dr = 1'b1; end
      checks++; if (level_w[1] !== 8'(lv)) begin errors++; $display("FAIL step100_level p=%0d: got %0d want %0d", k, level_w[1], lv); end
      checks++; if (dir_w[1] !== dr) begin errors++; $display("FAIL step100_dir p=%0d: got %b want %b", k, dir_w[1], dr); end
    end
  endtask

  task automatic test_back_to_back_ticks();
    int want [3][NI];
    want[0] = '{1, 100, 75};
    want[1] = '{2, 200, 150};
    want[2] = '{2, 200, 150};
    rst();
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 256; c++) begin
        if (p == 0) cyc(1'b1, c == 3 || c == 50 || c == 100 || c == 150 || c == 200);
        else if (p == 1) cyc(1'b1, c == 255);
        else cyc(1'b1, 1'b0);
      end
      for (int i = 0; i < NI; i++) begin
        checks++; if (level_w[i] !== 8'(want[p][i])) begin errors++; $display("FAIL multi_tick_level[%0d] p=%0d: got %0d want %0d", i, p, level_w[i], want[p][i]); end
      end
    end
  endtask

  task automatic test_en_drop();
    int first;
    rst();
    for (int p = 0; p < 40; p++)
      for (int c = 0; c < 256; c++) cyc(1'b1, c == 10);
    for (int c = 0; c < 130; c++) cyc(1'b1, c == 100);
    for (int k = 0; k < 50; k++) begin
      cyc(1'b0, 1'($urandom_range(1)));
      checks++; if (led_w[0] !== 1'b0) begin errors++; $display("FAIL endrop_led k=%0d: got %b want 0", k, led_w[0]); end
      checks++; if (wrap_w[0] !== 1'b0) begin errors++; $display("FAIL endrop_wrap k=%0d: got %b want 0", k, wrap_w[0]); end
      checks++; if (level_w[0] !== 8'd40) begin errors++; $display("FAIL endrop_level k=%0d: got %0d want 40", k, level_w[0]); end
    end
    first = -1;
    for (int k = 0; k < 300; k++) begin
      cyc(1'b1, 1'b0);
      if (wrap_w[0] === 1'b1) begin first = k + 1; break; end
    end
    checks++; if (first != 255) begin errors++; $display("FAIL endrop_first_wrap: got %0d want 255", first); end
    cyc(1'b1, 1'b0);
    checks++; if (level_w[0] !== 8'd40) begin errors++; $display("FAIL endrop_level_after: got %0d want 40", level_w[0]); end
  endtask

  task automatic test_async_reset();
    int first;
    rst();
    for (int p = 0; p < 7; p++)
      for (int c = 0; c < 256; c++) cyc(1'b1, c == 0);
    for (int c = 0; c < 60; c++) cyc(1'b1, 1'b0);
    checks++; if (level_w[2] !== 8'd180) begin errors++; $display("FAIL areset_pre_level: got %0d want 180", level_w[2]); end
    checks++; if (dir_w[2] !== 1'b0) begin errors++; $display("FAIL areset_pre_dir: got %b want 0", dir_w[2]); end
    #2 RESETN = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++; if (led_w[i] !== 1'b0) begin errors++; $display("FAIL areset_led[%0d]: got %b want 0", i, led_w[i]); end
      checks++; if (level_w[i] !== 8'd0) begin errors++; $display("FAIL areset_level[%0d]: got %0d want 0", i, level_w[i]); end
      checks++; if (dir_w[i] !== 1'b1) begin errors++; $display("FAIL areset_dir[%0d]: got %b want 1", i, dir_w[i]); end
      checks++; if (wrap_w[i] !== 1'b0) begin errors++; $display("FAIL areset_wrap[%0d]: got %b want 0", i, wrap_w[i]); end
    end
    #1 RESETN = 1'b1;
    mdl_clear();
    first = -1;
    for (int k = 0; k < 300; k++) begin
      cyc(1'b1, 1'b0);
      if (wrap_w[0] === 1'b1) begin first = k + 1; break; end
    end
    checks++; if (first != 255) begin errors++; $display("FAIL areset_first_wrap: got %0d want 255", first); end
  endtask

  task automatic test_random();
    bit en, tk;
    rst();
    for (int k = 0; k < 3000; k++) begin
      en = ($urandom_range(9) != 0);
      tk = ($urandom_range(7) == 0);
      cyc(en, tk);
      for (int i = 0; i < NI; i++) begin
        checks++; if (led_w[i] !== m[i].led) begin errors++; $display("FAIL rand_led[%0d] k=%0d: got %b want %b", i, k, led_w[i], m[i].led); end
        checks++; if (level_w[i] !== 8'(m[i].level)) begin errors++; $display("FAIL rand_level[%0d] k=%0d: got %0d want %0d", i, k, level_w[i], m[i].level); end
        checks++; if (dir_w[i] !== (m[i].phase < 2)) begin errors++; $display("FAIL rand_dir[%0d] k=%0d: got %b want %b", i, k, dir_w[i], m[i].phase < 2); end
        checks++; if (wrap_w[i] !== (en && m[i].cnt == MAXV)) begin errors++; $display("FAIL rand_wrap[%0d] k=%0d: got %b want %b", i, k, wrap_w[i], en && m[i].cnt == MAXV); end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    mdl_clear();
    test_reset();
    test_idle();
    test_duty64();
    test_step100();
    test_back_to_back_ticks();
    test_en_drop();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_breathe.md
LED_BREATHE -- requirements
Module: led_breathe

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8: width of the PWM counter and LEVEL; legal range 4..12.
REQ-002 SHALL have parameter STEP, default 1: LEVEL increment or decrement per applied tick; legal range 1..2^PWM_BITS-1.
REQ-003 SHALL have parameter HOLD_TICKS, default 16: applied ticks spent in each hold state; legal range 1..255.
REQ-004 SHALL have port CLK, input, 1 bit: sole clock, rising edge; every register is clocked by it.
REQ-005 SHALL have port RESETN, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port EN, input, 1 bit: run enable.
REQ-007 SHALL have port TICK, input, 1 bit: brightness-step request, normally the counter stage's COUT pulse.
REQ-008 SHALL have port LED, output, 1 bit: PWM drive for one LED pin (e.g. D5).
REQ-009 SHALL have port LEVEL, output, PWM_BITS bits: current duty value.
REQ-010 SHALL have port DIR, output, 1 bit: 1 in RAMP_UP or HOLD_HIGH, 0 otherwise.
REQ-011 SHALL have port WRAP, output, 1 bit: one-cycle pulse in the cycle where the PWM counter holds 2^PWM_BITS-1 and EN=1.

Function
REQ-012 SHALL hold an internal PWM counter CNT (PWM_BITS bits) that increments by 1 every cycle with EN=1 and wraps from 2^PWM_BITS-1 to 0.
REQ-013 SHALL register LED as EN && (CNT < LEVEL), giving one cycle of latency; LEVEL=0 gives a constant 0 and LEVEL=max gives (2^N-1)/2^N duty.
REQ-014 SHALL set a PENDING flag on any cycle with TICK=1 and EN=1; multiple ticks within one PWM period collapse into one.
REQ-015 SHALL apply a step only on a WRAP cycle with PENDING=1 or TICK=1, and SHALL then clear PENDING; a TICK in the WRAP cycle itself is consumed there.
REQ-016 SHALL implement FSM states RAMP_UP, HOLD_HIGH, RAMP_DOWN and HOLD_LOW, advancing only on applied steps.
REQ-017 In RAMP_UP, each applied step SHALL compute LEVEL+STEP in PWM_BITS+1 bits; if the sum is >= 2^N-1, LEVEL SHALL become 2^N-1 (saturate), the hold counter SHALL clear and the state SHALL go to HOLD_HIGH.
REQ-018 In HOLD_HIGH, each applied step SHALL increment the hold counter; on reaching HOLD_TICKS the counter SHALL clear and the state SHALL go to RAMP_DOWN.
REQ-019 In RAMP_DOWN, if LEVEL <= STEP, LEVEL SHALL become 0, the hold counter SHALL clear and the state SHALL go to HOLD_LOW; otherwise LEVEL SHALL become LEVEL-STEP (no underflow).
REQ-020 In HOLD_LOW, the state SHALL mirror HOLD_HIGH and go to RAMP_UP after HOLD_TICKS applied steps.
REQ-021 LEVEL SHALL change only at a WRAP boundary, so every PWM period uses a single duty value.
REQ-022 While EN=0: CNT SHALL be forced to 0, LED SHALL be 0, PENDING SHALL be cleared, WRAP SHALL be 0, and LEVEL, state and hold counter SHALL be held; TICK SHALL be ignored.
REQ-023 On EN rising, CNT SHALL restart at 0 and the first WRAP SHALL occur 2^N-1 cycles later.

Reset
REQ-024 When RESETN=0, the block SHALL immediately and asynchronously set CNT=0, LEVEL=0, LED=0, WRAP=0, PENDING=0, hold counter=0 and state=RAMP_UP (DIR=1).
REQ-025 RESETN asserted mid-period or mid-ramp SHALL abandon all progress; there is no partial-state retention.
REQ-026 Deassertion is synchronised externally; the first active edge after RESETN rises SHALL count CNT 0->1 if EN=1.

Verification
REQ-027 Defaults, EN=1, no TICK for 1024 cycles -> LED=0 throughout, WRAP every 256 cycles, LEVEL=0.
REQ-028 Defaults, LEVEL forced to 64 via 64 ticks, one per period -> LED high for exactly 64 of every 256 cycles, rising one cycle after CNT=0.
REQ-029 STEP=100, TICK every period -> LEVEL 0,100,200,255 then HOLD_HIGH for 16 periods, then 155,55,0 and HOLD_LOW; DIR toggles at the hold exits.
REQ-030 Five TICK pulses inside one period, plus a TICK coincident with the next WRAP -> exactly one step per WRAP and no lost or double step.
REQ-031 EN dropped at CNT=130 with LEVEL=40 for 50 cycles -> LED=0, CNT=0, LEVEL=40 held; after re-enable, WRAP occurs 255 cycles later.
REQ-032 RESETN pulsed low for under one clock period in RAMP_DOWN with LEVEL=180 -> all outputs clear without a clock edge; state=RAMP_UP, LEVEL=0.
